// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall / flush / bubble sequencing for the 5-stage pipeline:
//            load-use interlock, redirect flush, halt drain, perf counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_AW           = 4,
    parameter int REDIRECT_BUBBLES = 2,
    parameter int DRAIN_CYCLES     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_halt,
    input  logic              ex_memrd,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              redirect,
    output logic              stall,
    output logic              flush,
    output logic              bubble_ex,
    output logic              halted,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [3:0]  FLUSH_RELOAD = 4'(REDIRECT_BUBBLES - 1);
    localparam logic [3:0]  DRAIN_LOAD   = 4'(DRAIN_CYCLES);
    localparam bit          MULTI_FLUSH  = (REDIRECT_BUBBLES > 1);
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] count;
    logic [3:0] count_nxt;

    logic       rs1_match;
    logic       rs2_match;
    logic       lu_hit;

    logic       stall_raw;
    logic       flush_raw;
    logic       bubble_raw;
    logic       count_en;

    // Register 0 is hard-wired, so a load targeting it never interlocks.
    assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu_hit    = id_valid && ex_memrd && (ex_rd != '0) && (rs1_match || rs2_match);

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        stall_raw  = 1'b0;
        flush_raw  = 1'b0;
        bubble_raw = 1'b0;

        unique case (state)
            ST_RUN: begin
                // The ID instruction is wrong-path on a redirect, so it wins.
                if (redirect) begin
                    flush_raw = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_nxt = ST_FLUSH;
                        count_nxt = FLUSH_RELOAD;
                    end
                end else if (lu_hit) begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                end else if (id_valid && id_halt) begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    state_nxt  = ST_DRAIN;
                    count_nxt  = DRAIN_LOAD;
                end
            end

            ST_FLUSH: begin
                flush_raw = 1'b1;
                if (redirect && MULTI_FLUSH) begin
                    count_nxt = FLUSH_RELOAD;
                end else if (count <= 4'd1) begin
                    state_nxt = ST_RUN;
                    count_nxt = 4'd0;
                end else begin
                    count_nxt = count - 4'd1;
                end
            end

            ST_DRAIN: begin
                stall_raw  = 1'b1;
                bubble_raw = 1'b1;
                if (count <= 4'd1) begin
                    state_nxt = ST_HALTED;
                    count_nxt = 4'd0;
                end else begin
                    count_nxt = count - 4'd1;
                end
            end

            ST_HALTED: begin
                stall_raw  = 1'b1;
                bubble_raw = 1'b1;
            end

            default: begin
                state_nxt = ST_RUN;
                count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            count <= 4'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Mealy outputs are held low for the whole reset window, not just after it.
    assign stall     = stall_raw  && !rst;
    assign flush     = flush_raw  && !rst;
    assign bubble_ex = bubble_raw && !rst;
    assign halted    = (state == ST_HALTED) && !rst;

    assign count_en = (stall_raw || flush_raw) && (state != ST_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (count_en && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Scoreboard bench for pipe_hazard_ctrl against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int AW = 4;
    localparam int RB = 2;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic          id_halt = 1'b0;
    logic          ex_memrd = 1'b0;
    logic [AW-1:0] ex_rd = '0;
    logic          redirect = 1'b0;
    logic          stall;
    logic          flush;
    logic          bubble_ex;
    logic          halted;
    logic [15:0]   stall_cnt;

    pipe_hazard_ctrl #(
        .REG_AW(AW), .REDIRECT_BUBBLES(RB), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_halt(id_halt),
        .ex_memrd(ex_memrd), .ex_rd(ex_rd), .redirect(redirect),
        .stall(stall), .flush(flush), .bubble_ex(bubble_ex),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        bubble;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: remaining flush cycles, remaining drain cycles.
    int   m_flush_left;
    int   m_drain_left;
    bit   m_halted;
    int   m_cnt;

    task automatic model_reset();
        m_flush_left = 0;
        m_drain_left = 0;
        m_halted     = 1'b0;
        m_cnt        = 0;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_halt = 0; ex_memrd = 0; ex_rd = '0; redirect = 0;
    endtask

    task automatic step(input bit v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input bit u1, input bit u2, input bit h, input bit mr,
                        input logic [AW-1:0] rd, input bit rdr);
        exp_t e;
        bit   lu;
        @(negedge clk);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_halt = h; ex_memrd = mr; ex_rd = rd; redirect = rdr;
        lu = v && mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        e = '0;
        e.halted = m_halted;
        e.cnt    = 16'(m_cnt);
        if (m_halted) begin
            e.stall = 1; e.bubble = 1;
        end else if (m_drain_left > 0) begin
            e.stall = 1; e.bubble = 1;
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
        end else if (m_flush_left > 0) begin
            e.flush = 1;
            m_flush_left = rdr ? RB - 1 : m_flush_left - 1;
        end else if (rdr) begin
            e.flush = 1;
            m_flush_left = RB - 1;
        end else if (lu) begin
            e.stall = 1; e.bubble = 1;
        end else if (v && h) begin
            e.stall = 1; e.bubble = 1;
            m_drain_left = DC;
        end
        if ((e.stall || e.flush) && !e.halted && m_cnt < 65535) m_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic step_idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        set_idle();
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic check_now(input string name, input logic [19:0] act, input logic [19:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Sampled one cycle after the last step's clock edge, before the next edge.
    task automatic check_after(input string name, input logic halt_req, input logic [15:0] cnt_req);
        @(negedge clk);
        #3;
        check_now(name, {3'b000, halted, stall_cnt}, {3'b000, halt_req, cnt_req});
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the queue.
    always @(negedge clk) begin
        exp_t e;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({stall, flush, bubble_ex, halted, stall_cnt} !== e) begin
                errors++;
                $display("FAIL cycle t=%0t: got s=%b f=%b b=%b h=%b cnt=%0d required s=%b f=%b b=%b h=%b cnt=%0d",
                         $time, stall, flush, bubble_ex, halted, stall_cnt,
                         e.stall, e.flush, e.bubble, e.halted, e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        set_idle();
        #1;
        check_now("reset_outputs", {stall, flush, bubble_ex, halted, stall_cnt}, 20'h0);
        @(negedge clk);
        rst = 0;

        // Load-use on rs2, then the same with r0 as destination.
        step(1, 4'd5, 4'd3, 0, 1, 0, 1, 4'd3, 0);
        step(1, 4'd5, 4'd0, 0, 1, 0, 1, 4'd0, 0);
        check_after("loaduse_cnt", 1'b0, 16'd1);

        // Single redirect -> two flush cycles.
        do_reset();
        step(0, '0, '0, 0, 0, 0, 0, '0, 1);
        step_idle(2);
        check_after("redirect_cnt", 1'b0, 16'd2);

        // Redirect restarted in its second cycle -> three flush cycles.
        do_reset();
        step(0, '0, '0, 0, 0, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, 0, 0, '0, 1);
        step_idle(2);
        check_after("redirect2_cnt", 1'b0, 16'd3);

        // Redirect beats load-use and halt together.
        do_reset();
        step(1, 4'd2, 4'd2, 1, 1, 1, 1, 4'd2, 1);
        step_idle(DC + 2);
        check_after("combo_nohalt", 1'b0, 16'd2);

        // Halt: 1 + DC stall cycles, then halted with a frozen count.
        do_reset();
        step(1, '0, '0, 0, 0, 1, 0, '0, 0);
        step_idle(DC);
        check_after("halt_cnt", 1'b1, 16'(1 + DC));
        step_idle(3);
        check_after("halt_frozen", 1'b1, 16'(1 + DC));

        // Asynchronous reset in the middle of a drain.
        do_reset();
        step(1, '0, '0, 0, 0, 1, 0, '0, 0);
        step_idle(2);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check_now("async_rst", {stall, flush, bubble_ex, halted, stall_cnt}, 20'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        step_idle(3);

        // Randomised traffic with small register numbers to provoke hits.
        for (int i = 0; i < 3000; i++) begin
            bit rdr;
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            rdr = ($urandom_range(0, 7) == 0) && (m_drain_left == 0) && !m_halted;
            step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), $urandom_range(0, 40) == 0, 1'($urandom),
                 AW'($urandom_range(0, 3)), rdr);
        end

        // Saturation: 65534 preload stalls plus 3 more.
        do_reset();
        for (int i = 0; i < 65537; i++) step(1, 4'd7, '0, 1, 0, 0, 1, 4'd7, 0);
        step_idle(1);
        check_after("saturate", 1'b0, 16'hFFFF);

        @(negedge clk);
        #4;
        check_now("queue_drained", 20'(exp_q.size()), 20'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
